// File: rtl/uc_pkg.sv
// Shared definitions for the Booth multiplier control unit: state encodings,
// default operand width and the recoding helpers used by the FSM.
package uc_pkg;

  localparam int UC_N_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_OP    = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } uc_state_e;

  // Booth pair (q0, q(-1)): 00/11 need no add/sub step.
  function automatic logic booth_nop(input logic q0, input logic q_m1);
    return q0 == q_m1;
  endfunction

  function automatic logic booth_sub(input logic q0, input logic q_m1);
    return q0 & ~q_m1;
  endfunction

endpackage

// File: rtl/contador_iter.sv
// Iteration counter: loaded with N at the start of an operation, decremented
// on each shift, saturating at zero; 'last' flags the final iteration.
module contador_iter
  import uc_pkg::*;
#(
  parameter int N  = UC_N_DEF,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= CW'(N);
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/uc_booth_n.sv
// Control unit for a radix-2 Booth multiplier datapath (A:Q:Q(-1), M).
// Sequences load, add/sub and arithmetic-shift steps for N iterations.
module uc_booth_n
  import uc_pkg::*;
#(
  parameter int N        = UC_N_DEF,
  parameter bit SKIP_NOP = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_menos1,
  output logic Carga_QM,
  output logic Reset_A,
  output logic Carga_A,
  output logic Resta,
  output logic Desplaza_AQ,
  output logic Fin,
  output logic busy
);

  localparam int CW = $clog2(N + 1);

  uc_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          cnt_load;
  logic          is_nop;

  contador_iter #(.N(N), .CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (Desplaza_AQ),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  assign is_nop = booth_nop(q0, q_menos1);

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    Carga_QM    = 1'b0;
    Reset_A     = 1'b0;
    Carga_A     = 1'b0;
    Resta       = 1'b0;
    Desplaza_AQ = 1'b0;
    Fin         = 1'b0;
    busy        = 1'b0;
    cnt_load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        Carga_QM  = 1'b1;
        Reset_A   = 1'b1;
        cnt_load  = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_OP;
      end
      ST_OP: begin
        busy = 1'b1;
        if (!is_nop) begin
          Carga_A   = 1'b1;
          Resta     = booth_sub(q0, q_menos1);
          state_nxt = ST_SHIFT;
        end else if (SKIP_NOP) begin
          // Nothing to accumulate: fold the shift into this cycle.
          Desplaza_AQ = 1'b1;
          state_nxt   = cnt_last ? ST_DONE : ST_OP;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy        = 1'b1;
        Desplaza_AQ = 1'b1;
        state_nxt   = cnt_last ? ST_DONE : ST_OP;
      end
      ST_DONE: begin
        Fin = 1'b1;
        if (start) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  a_ctrl_excl: assert property (@(posedge clk) disable iff (reset)
    $onehot0({Carga_QM, Carga_A, Desplaza_AQ}));

endmodule

// File: tb/tb_uc_booth_n.sv
// Bench for uc_booth_n: two control units (SKIP_NOP 0/1) share a behavioural
// Booth datapath; a scoreboard holds expected latency, step counts and product.
module tb_uc_booth_n;
  import uc_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset, start, sel, hold, h_q0, h_qm;
  logic q0, qm, start0, start1;
  logic z_qm, z_ra, z_ca, z_rs, z_sh, z_fin, z_busy;
  logic s_qm, s_ra, s_ca, s_rs, s_sh, s_fin, s_busy;
  logic c_qm, c_ra, c_ca, c_rs, c_sh, c_fin, c_busy;
  logic l_qm, l_ra, l_ca, l_rs, l_sh;
  logic [N:0]   A;
  logic [N-1:0] Q, M, mcand, mplier;
  logic         qm1;
  int n_tests = 0, n_fail = 0, ovl = 0;

  typedef struct {
    int lat; int adds; int subs; int shifts;
    bit chk_prod; logic signed [2*N-1:0] prod;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  uc_booth_n #(.N(N), .SKIP_NOP(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start0), .q0(q0), .q_menos1(qm),
    .Carga_QM(z_qm), .Reset_A(z_ra), .Carga_A(z_ca), .Resta(z_rs),
    .Desplaza_AQ(z_sh), .Fin(z_fin), .busy(z_busy));

  uc_booth_n #(.N(N), .SKIP_NOP(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start1), .q0(q0), .q_menos1(qm),
    .Carga_QM(s_qm), .Reset_A(s_ra), .Carga_A(s_ca), .Resta(s_rs),
    .Desplaza_AQ(s_sh), .Fin(s_fin), .busy(s_busy));

  always_comb begin
    start0 = start && !sel;
    start1 = start && sel;
    q0     = hold ? h_q0 : Q[0];
    qm     = hold ? h_qm : qm1;
    {c_qm, c_ra, c_ca, c_rs, c_sh, c_fin, c_busy} = sel ?
      {s_qm, s_ra, s_ca, s_rs, s_sh, s_fin, s_busy} :
      {z_qm, z_ra, z_ca, z_rs, z_sh, z_fin, z_busy};
  end

  // Controls are sampled mid-cycle and applied to the datapath at the next edge.
  always @(negedge clk) begin
    {l_qm, l_ra, l_ca, l_rs, l_sh} <= {c_qm, c_ra, c_ca, c_rs, c_sh};
    if ((c_qm && c_ca) || (c_qm && c_sh) || (c_ca && c_sh)) ovl <= ovl + 1;
  end

  always @(posedge clk) begin
    if (l_qm) begin M <= mcand; Q <= mplier; qm1 <= 1'b0; end
    if (l_ra) A <= '0;
    if (l_ca) A <= l_rs ? A - {M[N-1], M} : A + {M[N-1], M};
    if (l_sh) {A, Q, qm1} <= {A[N], A, Q};
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic run_op(input bit s, input bit hd, input bit hq0, input bit hqm,
                        input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                        input bit poke);
    exp_t e;
    int k, na, ns, nsh, ov0;
    logic cur, prev;
    sel = s; hold = hd; h_q0 = hq0; h_qm = hqm; mcand = a; mplier = b;
    e.adds = 0; e.subs = 0;
    if (hd) begin
      if (hq0 && !hqm) e.subs = N;
      if (!hq0 && hqm) e.adds = N;
    end else begin
      for (int i = 0; i < N; i++) begin
        cur  = b[i];
        prev = (i == 0) ? 1'b0 : b[i-1];
        if (cur && !prev) e.subs++;
        if (!cur && prev) e.adds++;
      end
    end
    e.lat      = s ? N + 1 + e.adds + e.subs : 2 * N + 1;
    e.shifts   = N;
    e.chk_prod = !hd;
    e.prod     = (2*N)'(int'(a) * int'(b));
    sb.push_back(e);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ov0 = ovl;
    chk("load_qm", c_qm, 1);
    chk("fin_drop", c_fin, 0);
    chk("busy_load", c_busy, 1);
    k = 0; na = 0; ns = 0; nsh = 0;
    while (!c_fin && k < 200) begin
      if (c_ca && c_rs) ns++;
      else if (c_ca) na++;
      if (c_sh) nsh++;
      start = (poke && k == 5);
      @(negedge clk); k++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("latency", k, e.lat);
    chk("shifts", nsh, e.shifts);
    chk("adds", na, e.adds);
    chk("subs", ns, e.subs);
    chk("overlap", ovl - ov0, 0);
    chk("busy_done", c_busy, 0);
    if (e.chk_prod) chk("product", $signed({A[N-1:0], Q}), e.prod);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; sel = 1'b0; hold = 1'b1; h_q0 = 1'b0; h_qm = 1'b0;
    mcand = '0; mplier = '0;
    repeat (3) @(negedge clk);
    chk("rst_out0", {z_qm, z_ra, z_ca, z_rs, z_sh, z_fin, z_busy}, 0);
    chk("rst_out1", {s_qm, s_ra, s_ca, s_rs, s_sh, s_fin, s_busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", {z_busy, s_busy, z_fin, s_fin}, 0);

    run_op(1'b0, 1'b1, 1'b1, 1'b0, 8'sd0, 8'sd0, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 8'sd0, 8'sd0, 1'b0);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 8'sd3, -8'sd5, 1'b0);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, -8'sd8, 8'sd7, 1'b1);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, -8'sd128, -8'sd128, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 8'sd3, -8'sd5, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, -8'sd8, 8'sd7, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, -8'sd128, -8'sd128, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 8'sd85, 8'sd85, 1'b0);

    // Reset during a shift step, with start asserted on the same edge.
    sel = 1'b0; hold = 1'b1; h_q0 = 1'b1; h_qm = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    repeat (6) begin @(negedge clk); k++; end
    chk("in_shift", c_sh, 1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", {c_qm, c_ra, c_ca, c_rs, c_sh, c_fin, c_busy}, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", {c_busy, c_fin, c_qm}, 0);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 8'sd3, -8'sd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
